onchip_mem_arbiter: RTL and testbench
=====================================

Name: onchip_mem_arbiter

Overview:
- Two-master round-robin arbiter in front of the single-port 32-bit on-chip RAM (25000 words, 15-bit word address, 1-cycle read latency).
- Lets the Nios data master (m0) and a secondary master such as the DMA or game-state engine (m1) share the RAM's single port through Avalon-MM slave interfaces with waitrequest/readdatavalid.
- Drives the RAM's chipselect/write/byteenable/clken port directly.

Parameters:
- ADDR_W, 15, word-address width on both sides
- DATA_W, 32, data width; byteenable width is DATA_W/8
- MEM_WORDS, 25000, populated depth; word addresses >= MEM_WORDS are out of range

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- m0_address  in  ADDR_W  master 0 word address
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_byteenable  in  DATA_W/8  master 0 byte lanes
- m0_writedata  in  DATA_W  master 0 write data
- m0_waitrequest  out  1  master 0 stall
- m0_readdata  out  DATA_W  master 0 read data
- m0_readdatavalid  out  1  master 0 read data valid
- m1_*  (same seven signals as m0_*)  master 1
- mem_address  out  ADDR_W  RAM address
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write
- mem_byteenable  out  DATA_W/8  RAM byte lanes
- mem_writedata  out  DATA_W  RAM write data
- mem_clken  out  1  RAM clock enable
- mem_readdata  in  DATA_W  RAM read data, valid the cycle after the address is presented
- range_err  out  1  sticky out-of-range flag

Behaviour:
- Interface: one clock, clk. reset_n is synchronous and active-low.
- Reset values:
  - last_grant = 1, so m0 wins the first contest.
  - Read-return pipe cleared.
  - range_err = 0.
  - All mX_readdatavalid = 0.
  - mem_clken = 1 at all times; mem_chipselect/mem_write = 0.
- Request: mX_req = mX_read | mX_write. read and write asserted together is illegal and is treated as a write.
- Arbitration (combinational, per cycle):
  - Only one master requesting: that master is granted.
  - Both requesting: the master not equal to last_grant is granted.
  - last_grant updates on every cycle that has a grant.
- Waitrequest: mX_waitrequest = mX_req & ~grantX. Masters hold their command stable while stalled (Avalon rule). The loser is guaranteed the grant on the next cycle.
- Memory drive:
  - The granted master's address, byteenable and writedata are muxed to mem_*.
  - mem_chipselect = grant_any & in_range.
  - mem_write = granted write & in_range.
  - With no grant, mem_* hold the m0 values and chipselect = 0.
- Throughput: one access per cycle, no bubbles between back-to-back grants.
- Read return:
  - A read granted in cycle t sets a registered pipe entry {valid, owner, oor}.
  - In cycle t+1, m<owner>_readdatavalid = 1 and m<owner>_readdata = oor ? 0 : mem_readdata.
  - The other master's readdatavalid = 0. Readdata is don't-care when valid is low but is driven with mem_readdata.
- Writes: no response, complete in the grant cycle.
- Out of range (address >= MEM_WORDS):
  - Write is dropped (chipselect held low).
  - Read completes normally with data 0.
  - range_err is set and stays set until reset.
- Simultaneous events: a grant in cycle t+1 may coincide with the return of the read issued in t; both proceed.
- Reset mid-operation: a pending readdatavalid is killed on the reset edge. The master is expected to be reset by the same reset_n.

Optional Feature:
- Macro: ONCHIP_MEM_ARB_PERF_EN
- Defined:
  - Adds outputs m0_grant_cnt, m1_grant_cnt and stall_cnt (32-bit each).
  - m0_grant_cnt / m1_grant_cnt count grants per master; stall_cnt counts cycles with any waitrequest high.
  - All counters saturate at all-ones and clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package onchip_mem_arb_pkg holds:
  - Constants ADDR_W_DEF=15, DATA_W_DEF=32, MEM_WORDS_DEF=25000.
  - typedef master_id_t (1-bit enum M0/M1).
  - typedef rd_pipe_t struct {valid, owner, oor}.
- One sub-module: rr_arb2. It is the 2-way round-robin grant logic holding the last_grant register and is reusable for other shared slaves.

Test Plan:
- Single read: m0 writes 0xDEADBEEF to 0x0010 with byteenable 0xF, then reads 0x0010 → waitrequest 0 both cycles; m0_readdatavalid=1 one cycle after the read with 0xDEADBEEF; m1_readdatavalid stays 0.
- Contention: m0 and m1 both read (0x0001 / 0x0002) from reset → m0 granted cycle t, m1 waitrequest=1 at t and granted at t+1; returns are m0 at t+1 and m1 at t+2. With continuous requests from both, grants strictly alternate.
- Byte lanes: m1 writes 0x11223344 with byteenable 0x5 over 0xFFFFFFFF at 0x0100 → readback 0xFF22FF44.
- Out of range: m0 writes 0xA5A5A5A5 to 25000, then reads 25000 → mem_chipselect stays 0; read returns 0; range_err=1 and stays 1; 0x61A8 mod depth is untouched.
- Reset mid-read: m1 read granted, then reset_n=0 on the next edge → no m1_readdatavalid; after release, m0 wins the first contest.
- ONCHIP_MEM_ARB_PERF_EN defined: 10 cycles of both masters requesting → m0_grant_cnt=5, m1_grant_cnt=5, stall_cnt=10.

Source files
------------

// File: rtl/onchip_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : onchip_mem_arb_pkg
// Brief  : Shared constants and types for the on-chip RAM arbiter.
// Rev    : 1.0
// ============================================================================
package onchip_mem_arb_pkg;

    localparam int ADDR_W_DEF    = 15;
    localparam int DATA_W_DEF    = 32;
    localparam int MEM_WORDS_DEF = 25000;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_t;

    typedef struct packed {
        logic       valid;
        master_id_t owner;
        logic       oor;
    } rd_pipe_t;

    function automatic master_id_t other_master(input master_id_t id);
        return (id == M0) ? M1 : M0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onchip_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : onchip_mem_arbiter_if
// Brief  : Avalon-MM bus (waitrequest / readdatavalid) between a master and
//          one arbiter slave port.
// Rev    : 1.0
// ============================================================================
interface onchip_mem_arbiter_if #(
    parameter int ADDR_W = onchip_mem_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = onchip_mem_arb_pkg::DATA_W_DEF
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin grant logic with last-grant register.
// Rev    : 1.0
// ============================================================================
module rr_arb2
    import onchip_mem_arb_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset_n,
    input  wire logic [1:0] i_req,
    output logic      [1:0] o_grant,
    output logic            o_grant_any,
    output master_id_t      o_winner
);

    master_id_t r_last_grant;

    // With no request the winner parks on M0 so downstream muxes default to m0.
    always_comb begin
        o_winner = M0;
        case (i_req)
            2'b01:   o_winner = M0;
            2'b10:   o_winner = M1;
            2'b11:   o_winner = other_master(r_last_grant);
            default: o_winner = M0;
        endcase
        o_grant_any = |i_req;
        o_grant     = 2'b00;
        if (o_grant_any) begin
            o_grant = (o_winner == M1) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last_grant <= M1;
        end else if (o_grant_any) begin
            r_last_grant <= o_winner;
        end
    end

endmodule
`default_nettype wire

// File: rtl/onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : onchip_mem_arbiter
// Brief  : Two-master round-robin arbiter for the single-port on-chip RAM.
//          Optional ONCHIP_MEM_ARB_PERF_EN adds saturating grant/stall counters.
// Rev    : 1.0
// ============================================================================
module onchip_mem_arbiter
    import onchip_mem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  wire logic                clk,
    input  wire logic                reset_n,
    onchip_mem_arbiter_if.slave      m0,
    onchip_mem_arbiter_if.slave      m1,
    output logic [ADDR_W-1:0]        mem_address,
    output logic                     mem_chipselect,
    output logic                     mem_write,
    output logic [DATA_W/8-1:0]      mem_byteenable,
    output logic [DATA_W-1:0]        mem_writedata,
    output logic                     mem_clken,
    input  wire logic [DATA_W-1:0]   mem_readdata,
    output logic                     range_err
`ifdef ONCHIP_MEM_ARB_PERF_EN
    ,
    output logic [31:0]              m0_grant_cnt,
    output logic [31:0]              m1_grant_cnt,
    output logic [31:0]              stall_cnt
`endif
);

    localparam logic [31:0] c_mem_words = 32'(MEM_WORDS);

    logic             w_req0;
    logic             w_req1;
    logic [1:0]       w_grant;
    logic             w_grant_any;
    master_id_t       w_winner;
    logic             w_sel_write;
    logic             w_in_range;
    logic [ADDR_W-1:0] w_addr;
    rd_pipe_t         w_pipe_nxt;
    rd_pipe_t         r_pipe;
    logic             r_range_err;

    // A simultaneous read+write counts as a write, so write is the only qualifier.
    assign w_req0 = m0.read | m0.write;
    assign w_req1 = m1.read | m1.write;

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_req       ({w_req1, w_req0}),
        .o_grant     (w_grant),
        .o_grant_any (w_grant_any),
        .o_winner    (w_winner)
    );

    always_comb begin
        w_addr         = m0.address;
        mem_byteenable = m0.byteenable;
        mem_writedata  = m0.writedata;
        w_sel_write    = m0.write;
        if (w_winner == M1) begin
            w_addr         = m1.address;
            mem_byteenable = m1.byteenable;
            mem_writedata  = m1.writedata;
            w_sel_write    = m1.write;
        end
    end

    assign w_in_range     = (32'(w_addr) < c_mem_words);
    assign mem_address    = w_addr;
    assign mem_chipselect = w_grant_any & w_in_range;
    assign mem_write      = w_grant_any & w_sel_write & w_in_range;
    assign mem_clken      = 1'b1;

    always_comb begin
        w_pipe_nxt.valid = w_grant_any & ~w_sel_write;
        w_pipe_nxt.owner = w_winner;
        w_pipe_nxt.oor   = ~w_in_range;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pipe      <= '0;
            r_range_err <= 1'b0;
        end else begin
            r_pipe <= w_pipe_nxt;
            if (w_grant_any && !w_in_range) begin
                r_range_err <= 1'b1;
            end
        end
    end

    assign range_err = r_range_err;

    assign m0.waitrequest   = w_req0 & ~w_grant[0];
    assign m1.waitrequest   = w_req1 & ~w_grant[1];
    assign m0.readdatavalid = r_pipe.valid & (r_pipe.owner == M0);
    assign m1.readdatavalid = r_pipe.valid & (r_pipe.owner == M1);
    // Out-of-range reads never selected the RAM, so its output is stale: force 0.
    assign m0.readdata = (m0.readdatavalid && r_pipe.oor) ? '0 : mem_readdata;
    assign m1.readdata = (m1.readdatavalid && r_pipe.oor) ? '0 : mem_readdata;

`ifdef ONCHIP_MEM_ARB_PERF_EN
    logic [31:0] r_m0_grant_cnt;
    logic [31:0] r_m1_grant_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_any_wait;

    assign w_any_wait = m0.waitrequest | m1.waitrequest;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_m0_grant_cnt <= '0;
            r_m1_grant_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (w_grant[0] && (r_m0_grant_cnt != '1)) begin
                r_m0_grant_cnt <= r_m0_grant_cnt + 32'd1;
            end
            if (w_grant[1] && (r_m1_grant_cnt != '1)) begin
                r_m1_grant_cnt <= r_m1_grant_cnt + 32'd1;
            end
            if (w_any_wait && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign m0_grant_cnt = r_m0_grant_cnt;
    assign m1_grant_cnt = r_m1_grant_cnt;
    assign stall_cnt    = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_onchip_mem_arbiter
// Brief  : Self-checking bench: directed vector table, hand sequences and a
//          randomized run against a transaction-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_onchip_mem_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    onchip_mem_arbiter_if m0_if ();
    onchip_mem_arbiter_if m1_if ();

    logic [14:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata = '0;
    logic        range_err;
`ifdef ONCHIP_MEM_ARB_PERF_EN
    logic [31:0] m0_grant_cnt;
    logic [31:0] m1_grant_cnt;
    logic [31:0] stall_cnt;
`endif

    onchip_mem_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0             (m0_if),
        .m1             (m1_if),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .range_err      (range_err)
`ifdef ONCHIP_MEM_ARB_PERF_EN
        ,
        .m0_grant_cnt   (m0_grant_cnt),
        .m1_grant_cnt   (m1_grant_cnt),
        .stall_cnt      (stall_cnt)
`endif
    );

    // Single-port RAM, one-cycle read latency.
    logic [31:0] ram  [0:32767] = '{default: 32'h0};
    logic [31:0] gold [0:32767] = '{default: 32'h0};

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [14:0] a0,
                         input logic [31:0] d0, input logic [3:0] b0,
                         input logic r1, input logic w1, input logic [14:0] a1,
                         input logic [31:0] d1, input logic [3:0] b1);
        m0_if.read = r0; m0_if.write = w0; m0_if.address = a0;
        m0_if.writedata = d0; m0_if.byteenable = b0;
        m1_if.read = r1; m1_if.write = w1; m1_if.address = a1;
        m1_if.writedata = d1; m1_if.byteenable = b1;
    endtask

    task automatic idle();
        drive(0, 0, 15'h0, 32'h0, 4'h0, 0, 0, 15'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        tick(); tick(); tick();
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic rd0, wr0; logic [14:0] a0; logic [31:0] d0; logic [3:0] be0;
        logic rd1, wr1; logic [14:0] a1; logic [31:0] d1; logic [3:0] be1;
        logic e_w0, e_w1, e_cs, e_we; logic [14:0] e_addr;
        logic e_v0, e_v1; logic [31:0] e_rd; logic e_err;
    } vec_t;

    function automatic vec_t mk(
        input logic rd0, input logic wr0, input logic [14:0] a0, input logic [31:0] d0, input logic [3:0] be0,
        input logic rd1, input logic wr1, input logic [14:0] a1, input logic [31:0] d1, input logic [3:0] be1,
        input logic e_w0, input logic e_w1, input logic e_cs, input logic e_we, input logic [14:0] e_addr,
        input logic e_v0, input logic e_v1, input logic [31:0] e_rd, input logic e_err);
        vec_t v;
        v.rd0 = rd0; v.wr0 = wr0; v.a0 = a0; v.d0 = d0; v.be0 = be0;
        v.rd1 = rd1; v.wr1 = wr1; v.a1 = a1; v.d1 = d1; v.be1 = be1;
        v.e_w0 = e_w0; v.e_w1 = e_w1; v.e_cs = e_cs; v.e_we = e_we; v.e_addr = e_addr;
        v.e_v0 = e_v0; v.e_v1 = e_v1; v.e_rd = e_rd; v.e_err = e_err;
        return v;
    endfunction

    vec_t tbl [12];

    // Reference model state for the randomized phase.
    int          last_g;
    bit          pv;
    int          pown;
    logic [31:0] pdata;
    bit          merr;
    logic        rd   [2];
    logic        wr   [2];
    logic [14:0] ad   [2];
    logic [31:0] dt   [2];
    logic [3:0]  be   [2];
    bit          held [2];
    bit          req  [2];
    int          g;
    bit          oor;

    initial begin
        tbl[0]  = mk(0,1,15'h10,32'hDEADBEEF,4'hF, 0,0,15'h0,32'h0,4'h0,       0,0,1,1,15'h10,   0,0,32'h0,0);
        tbl[1]  = mk(1,0,15'h10,32'h0,4'h0,       0,0,15'h0,32'h0,4'h0,       0,0,1,0,15'h10,   0,0,32'h0,0);
        tbl[2]  = mk(0,0,15'h0,32'h0,4'h0,        0,0,15'h0,32'h0,4'h0,       0,0,0,0,15'h0,    1,0,32'hDEADBEEF,0);
        tbl[3]  = mk(0,0,15'h0,32'h0,4'h0,        0,1,15'h100,32'hFFFFFFFF,4'hF, 0,0,1,1,15'h100, 0,0,32'h0,0);
        tbl[4]  = mk(0,0,15'h0,32'h0,4'h0,        0,1,15'h100,32'h11223344,4'h5, 0,0,1,1,15'h100, 0,0,32'h0,0);
        tbl[5]  = mk(0,0,15'h0,32'h0,4'h0,        1,0,15'h100,32'h0,4'h0,     0,0,1,0,15'h100,  0,0,32'h0,0);
        tbl[6]  = mk(0,0,15'h0,32'h0,4'h0,        0,0,15'h0,32'h0,4'h0,       0,0,0,0,15'h0,    0,1,32'hFF22FF44,0);
        tbl[7]  = mk(0,1,15'd25000,32'hA5A5A5A5,4'hF, 0,0,15'h0,32'h0,4'h0,   0,0,0,0,15'd25000,0,0,32'h0,0);
        tbl[8]  = mk(1,0,15'd25000,32'h0,4'h0,    0,0,15'h0,32'h0,4'h0,       0,0,0,0,15'd25000,0,0,32'h0,1);
        tbl[9]  = mk(0,0,15'h0,32'h0,4'h0,        0,0,15'h0,32'h0,4'h0,       0,0,0,0,15'h0,    1,0,32'h0,1);
        tbl[10] = mk(1,0,15'h0,32'h0,4'h0,        0,0,15'h0,32'h0,4'h0,       0,0,1,0,15'h0,    0,0,32'h0,1);
        tbl[11] = mk(0,0,15'h0,32'h0,4'h0,        0,0,15'h0,32'h0,4'h0,       0,0,0,0,15'h0,    1,0,32'h0,1);

        // Reset state
        reset_n = 1'b0;
        idle();
        tick(); tick();
        #4;
        chk("rst_rdv0", 32'(m0_if.readdatavalid), 32'h0);
        chk("rst_rdv1", 32'(m1_if.readdatavalid), 32'h0);
        chk("rst_range_err", 32'(range_err), 32'h0);
        chk("rst_cs", 32'(mem_chipselect), 32'h0);
        chk("rst_we", 32'(mem_write), 32'h0);
        chk("rst_clken", 32'(mem_clken), 32'h1);
        tick();
        reset_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rd0, tbl[i].wr0, tbl[i].a0, tbl[i].d0, tbl[i].be0,
                  tbl[i].rd1, tbl[i].wr1, tbl[i].a1, tbl[i].d1, tbl[i].be1);
            #4;
            chk($sformatf("tbl%0d_wait0", i), 32'(m0_if.waitrequest), 32'(tbl[i].e_w0));
            chk($sformatf("tbl%0d_wait1", i), 32'(m1_if.waitrequest), 32'(tbl[i].e_w1));
            chk($sformatf("tbl%0d_cs", i), 32'(mem_chipselect), 32'(tbl[i].e_cs));
            chk($sformatf("tbl%0d_we", i), 32'(mem_write), 32'(tbl[i].e_we));
            chk($sformatf("tbl%0d_addr", i), 32'(mem_address), 32'(tbl[i].e_addr));
            chk($sformatf("tbl%0d_rdv0", i), 32'(m0_if.readdatavalid), 32'(tbl[i].e_v0));
            chk($sformatf("tbl%0d_rdv1", i), 32'(m1_if.readdatavalid), 32'(tbl[i].e_v1));
            chk($sformatf("tbl%0d_range_err", i), 32'(range_err), 32'(tbl[i].e_err));
            if (tbl[i].e_v0) chk($sformatf("tbl%0d_rdata0", i), m0_if.readdata, tbl[i].e_rd);
            if (tbl[i].e_v1) chk($sformatf("tbl%0d_rdata1", i), m1_if.readdata, tbl[i].e_rd);
            tick();
        end
        chk("oor_ram_untouched", ram[25000], 32'h0);
        gold[15'h10]  = 32'hDEADBEEF;
        gold[15'h100] = 32'hFF22FF44;

        // Preload words 1 and 2 for the contention sequence
        drive(0, 1, 15'd1, 32'h01010101, 4'hF, 0, 0, 15'h0, 32'h0, 4'h0);
        tick();
        drive(0, 0, 15'h0, 32'h0, 4'h0, 0, 1, 15'd2, 32'h02020202, 4'hF);
        tick();
        gold[1] = 32'h01010101;
        gold[2] = 32'h02020202;

        // Reset mid-read: m1 read granted, reset sampled on the same edge
        drive(0, 0, 15'h0, 32'h0, 4'h0, 1, 0, 15'h100, 32'h0, 4'h0);
        reset_n = 1'b0;
        #4;
        chk("mrst_wait1", 32'(m1_if.waitrequest), 32'h0);
        tick();
        reset_n = 1'b1;
        idle();
        #4;
        chk("mrst_rdv1", 32'(m1_if.readdatavalid), 32'h0);
        chk("mrst_rdv0", 32'(m0_if.readdatavalid), 32'h0);
        chk("mrst_range_err_clr", 32'(range_err), 32'h0);
        tick();

        // Contention straight out of reset: m0 first, m1 next cycle
        drive(1, 0, 15'd1, 32'h0, 4'h0, 1, 0, 15'd2, 32'h0, 4'h0);
        #4;
        chk("cont_t_wait0", 32'(m0_if.waitrequest), 32'h0);
        chk("cont_t_wait1", 32'(m1_if.waitrequest), 32'h1);
        chk("cont_t_addr", 32'(mem_address), 32'd1);
        tick();
        drive(0, 0, 15'h0, 32'h0, 4'h0, 1, 0, 15'd2, 32'h0, 4'h0);
        #4;
        chk("cont_t1_wait1", 32'(m1_if.waitrequest), 32'h0);
        chk("cont_t1_addr", 32'(mem_address), 32'd2);
        chk("cont_t1_rdv0", 32'(m0_if.readdatavalid), 32'h1);
        chk("cont_t1_rdata0", m0_if.readdata, 32'h01010101);
        chk("cont_t1_rdv1", 32'(m1_if.readdatavalid), 32'h0);
        tick();
        idle();
        #4;
        chk("cont_t2_rdv1", 32'(m1_if.readdatavalid), 32'h1);
        chk("cont_t2_rdata1", m1_if.readdata, 32'h02020202);
        chk("cont_t2_rdv0", 32'(m0_if.readdatavalid), 32'h0);
        tick();

`ifdef ONCHIP_MEM_ARB_PERF_EN
        do_reset();
        drive(1, 0, 15'd3, 32'h0, 4'h0, 1, 0, 15'd4, 32'h0, 4'h0);
        for (int i = 0; i < 10; i++) tick();
        idle();
        #4;
        chk("perf_m0_grants", m0_grant_cnt, 32'd5);
        chk("perf_m1_grants", m1_grant_cnt, 32'd5);
        chk("perf_stalls", stall_cnt, 32'd10);
        tick();
`endif

        // Randomized run against the transaction-level model
        do_reset();
        last_g = 1; pv = 0; pown = 0; pdata = '0; merr = 0;
        held[0] = 0; held[1] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                if (!held[m]) begin
                    int r;
                    r = int'($urandom_range(0, 9));
                    rd[m] = (r >= 3 && r <= 5) || (r == 9);
                    wr[m] = (r >= 6);
                    ad[m] = ($urandom_range(0, 15) == 0) ? 15'($urandom_range(25000, 32767))
                                                         : 15'($urandom_range(0, 63));
                    dt[m] = $urandom;
                    be[m] = 4'($urandom_range(0, 15));
                end
                req[m] = rd[m] | wr[m];
            end
            drive(rd[0], wr[0], ad[0], dt[0], be[0], rd[1], wr[1], ad[1], dt[1], be[1]);

            if (req[0] && req[1]) g = 1 - last_g;
            else if (req[0])      g = 0;
            else if (req[1])      g = 1;
            else                  g = -1;
            oor = (g >= 0) ? (ad[g] >= 15'd25000) : 1'b0;

            #4;
            chk("rnd_wait0", 32'(m0_if.waitrequest), 32'(req[0] && g != 0));
            chk("rnd_wait1", 32'(m1_if.waitrequest), 32'(req[1] && g != 1));
            chk("rnd_cs", 32'(mem_chipselect), 32'(g >= 0 && !oor));
            chk("rnd_we", 32'(mem_write), 32'(g >= 0 && !oor && wr[g]));
            chk("rnd_addr", 32'(mem_address), 32'((g == 1) ? ad[1] : ad[0]));
            chk("rnd_rdv0", 32'(m0_if.readdatavalid), 32'(pv && pown == 0));
            chk("rnd_rdv1", 32'(m1_if.readdatavalid), 32'(pv && pown == 1));
            if (pv && pown == 0) chk("rnd_rdata0", m0_if.readdata, pdata);
            if (pv && pown == 1) chk("rnd_rdata1", m1_if.readdata, pdata);
            chk("rnd_range_err", 32'(range_err), 32'(merr));

            pv = 0;
            if (g >= 0) begin
                if (oor) merr = 1;
                if (!wr[g]) begin
                    pv = 1;
                    pown = g;
                    pdata = oor ? 32'h0 : gold[ad[g]];
                end else if (!oor) begin
                    for (int b = 0; b < 4; b++)
                        if (be[g][b]) gold[ad[g]][8*b +: 8] = dt[g][8*b +: 8];
                end
                last_g = g;
            end
            held[0] = req[0] && (g != 0);
            held[1] = req[1] && (g != 1);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
